// File: rtl/lfsr_seq_monitor.sv
// rtl/lfsr_seq_monitor.sv - checker for a 3-bit loadable feedback shift-register generator
// Optional err_cnt output enabled by defining SEQ_MON_ERRCNT_EN.
module lfsr_seq_monitor #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       q_in,
  input  logic             ld_in,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             mismatch,
  output logic             err_sticky,
  output logic             lockup,
  output logic             busy
`ifdef SEQ_MON_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ARMED, TRACK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [2:0]       seed;
  logic [2:0]       pred;
  logic [CNT_W-1:0] cnt;

  function automatic logic [2:0] nxt(input logic [2:0] s);
    return {s[1] ^ s[2], s[0], s[2]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      seed       <= '0;
      pred       <= '0;
      cnt        <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      lockup     <= 1'b0;
      busy       <= 1'b0;
`ifdef SEQ_MON_ERRCNT_EN
      err_cnt    <= '0;
`endif
    end else begin
      lockup     <= (state == TRACK) && (q_in == 3'b000);
      busy       <= (state == ARMED) || (state == TRACK);
      mismatch   <= 1'b0;
      period_vld <= 1'b0;
      if (ld_in) begin
        state      <= ARMED;
        err_sticky <= 1'b0;
        cnt        <= '0;
`ifdef SEQ_MON_ERRCNT_EN
        err_cnt    <= '0;
`endif
      end else begin
        case (state)
          ARMED: begin
            seed  <= q_in;
            pred  <= nxt(q_in);
            cnt   <= CNT_ONE;
            state <= TRACK;
          end
          TRACK: begin
            if (q_in != pred) begin
              mismatch   <= 1'b1;
              err_sticky <= 1'b1;
`ifdef SEQ_MON_ERRCNT_EN
              if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
`endif
            end
            // Resync on every sample so one glitch yields exactly one mismatch pulse.
            pred <= nxt(q_in);
            if (q_in == seed) begin
              period     <= cnt;
              period_vld <= 1'b1;
              cnt        <= CNT_ONE;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_ONE;
            end
          end
          IDLE:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_seq_monitor.sv
// tb/tb_lfsr_seq_monitor.sv - self-checking bench for lfsr_seq_monitor
module tb_lfsr_seq_monitor;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       q_in = '0;
  logic             ld_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             mismatch;
  logic             err_sticky;
  logic             lockup;
  logic             busy;
`ifdef SEQ_MON_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

  lfsr_seq_monitor #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .ld_in(ld_in),
    .period(period), .period_vld(period_vld), .mismatch(mismatch),
    .err_sticky(err_sticky), .lockup(lockup), .busy(busy)
`ifdef SEQ_MON_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: the generator's maximal cycle as a plain ordered list.
  int seq_tab [7] = '{1, 2, 4, 5, 7, 3, 6};

  function automatic logic [2:0] succ(input logic [2:0] v);
    if (v == 3'd0) return 3'd0;
    for (int i = 0; i < 7; i++)
      if (seq_tab[i] == int'(v)) return 3'(seq_tab[(i + 1) % 7]);
    return 3'd0;
  endfunction

  // Model: mode 0=idle 1=armed 2=track; period measured as elapsed edges since seed last seen.
  int         mode = 0;
  int         cyc = 0;
  int         t_seed = 0;
  logic [2:0] m_seed = '0;
  logic [2:0] m_prev = '0;
  int         e_period = 0, e_vld = 0, e_mm = 0, e_sticky = 0, e_lock = 0, e_busy = 0, e_errcnt = 0;
  logic [2:0] g = '0;
  int         vld_seen = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [2:0] q);
    rst = r; ld_in = l; q_in = q;
    @(posedge clk);
    cyc++;
    if (r) begin
      mode = 0; e_period = 0; e_vld = 0; e_mm = 0; e_sticky = 0;
      e_lock = 0; e_busy = 0; e_errcnt = 0;
    end else begin
      e_lock = (mode == 2 && q == 3'd0) ? 1 : 0;
      e_busy = (mode != 0) ? 1 : 0;
      e_mm = 0; e_vld = 0;
      if (l) begin
        mode = 1; e_sticky = 0; e_errcnt = 0;
      end else if (mode == 1) begin
        m_seed = q; m_prev = q; t_seed = cyc; mode = 2;
      end else if (mode == 2) begin
        if (q != succ(m_prev)) begin
          e_mm = 1; e_sticky = 1;
          if (e_errcnt < SAT) e_errcnt++;
        end
        if (q == m_seed) begin
          e_period = (cyc - t_seed > SAT) ? SAT : cyc - t_seed;
          e_vld = 1; t_seed = cyc;
        end
        m_prev = q;
      end
    end
    #1;
    chk("period", 8'(period), 8'(e_period));
    chk("period_vld", 8'(period_vld), 8'(e_vld));
    chk("mismatch", 8'(mismatch), 8'(e_mm));
    chk("err_sticky", 8'(err_sticky), 8'(e_sticky));
    chk("lockup", 8'(lockup), 8'(e_lock));
    chk("busy", 8'(busy), 8'(e_busy));
`ifdef SEQ_MON_ERRCNT_EN
    chk("err_cnt", 8'(err_cnt), 8'(e_errcnt));
`endif
    if (period_vld === 1'b1) vld_seen++;
  endtask

  // Drive one generator cycle; inj overrides the sampled output, and the generator continues from it.
  task automatic gen(input logic l, input logic [2:0] v, input bit inj, input logic [2:0] iv);
    logic [2:0] q;
    q = inj ? iv : g;
    step(1'b0, l, q);
    g = l ? v : succ(q);
  endtask

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 2; i++) step(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'($urandom_range(0, 7)));

    // Seed 001: correct generator, periods after E8 and E15
    gen(1'b1, 3'd1, 0, 3'd0);
    vld_seen = 0;
    for (int i = 1; i <= 15; i++) gen(1'b0, 3'd0, 0, 3'd0);
    chk("vld_pulses_seed1", 8'(vld_seen), 8'd2);
    chk("period7", 8'(period), 8'd7);

    // Seed 000: lock-up
    gen(1'b1, 3'd0, 0, 3'd0);
    for (int i = 1; i <= 5; i++) gen(1'b0, 3'd0, 0, 3'd0);
    chk("lockup_level", 8'(lockup), 8'd1);
    chk("period1", 8'(period), 8'd1);

    // Seed 001 with a glitch at E3
    gen(1'b1, 3'd1, 0, 3'd0);
    gen(1'b0, 3'd0, 0, 3'd0);
    gen(1'b0, 3'd0, 0, 3'd0);
    gen(1'b0, 3'd0, 1, 3'b110);
    gen(1'b0, 3'd0, 0, 3'd0);
    chk("glitch_period", 8'(period), 8'd3);
    for (int i = 0; i < 3; i++) gen(1'b0, 3'd0, 0, 3'd0);

    // Mid-track reload with 101
    gen(1'b1, 3'b101, 0, 3'd0);
    chk("reload_sticky", 8'(err_sticky), 8'd0);
    for (int i = 0; i < 9; i++) gen(1'b0, 3'd0, 0, 3'd0);
    chk("reload_period", 8'(period), 8'd7);

    // Counter saturation: seed 001, then hold 000 so the seed never reappears
    gen(1'b1, 3'd1, 0, 3'd0);
    gen(1'b0, 3'd0, 0, 3'd0);
    for (int i = 0; i < 20; i++) gen(1'b0, 3'd0, 1, 3'd0);
    gen(1'b0, 3'd0, 1, 3'd1);
    chk("sat_period", 8'(period), 8'(SAT));

    // Load held several cycles
    for (int i = 0; i < 3; i++) gen(1'b1, 3'b011, 0, 3'd0);
    for (int i = 0; i < 8; i++) gen(1'b0, 3'd0, 0, 3'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 39);
      if (r == 0) begin
        logic [2:0] v;
        v = 3'($urandom_range(0, 7));
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) gen(1'b1, v, 0, 3'd0);
      end else if (r <= 3) begin
        gen(1'b0, 3'd0, 1, 3'($urandom_range(0, 7)));
      end else if (r == 39) begin
        step(1'b1, 1'($urandom_range(0, 1)), g);
        g = succ(g);
      end else begin
        gen(1'b0, 3'd0, 0, 3'd0);
      end
    end

    // Reset mid-track at cnt=4
    gen(1'b1, 3'd1, 0, 3'd0);
    for (int i = 0; i < 4; i++) gen(1'b0, 3'd0, 0, 3'd0);
    step(1'b1, 1'b0, g);
    g = succ(g);
    chk("rst_busy", 8'(busy), 8'd0);
    vld_seen = 0;
    for (int i = 0; i < 10; i++) gen(1'b0, 3'd0, 0, 3'd0);
    chk("rst_no_vld", 8'(vld_seen), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
